// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between execute stage and mult_div_unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Execute stage side: issues requests and MTHI/MTLO writes, observes HI/LO
  modport master (
    output start, op, rs, rt, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  // Unit side
  modport slave (
    input  start, op, rs, rt, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (optional MDU_EARLY_OUT_EN multiply early-out)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          CLK,
  input  logic          RST,
  mult_div_unit_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]        r_count;
  logic                 r_is_div;
  logic                 r_sa;         // dividend/multiplicand was negative (signed ops only)
  logic                 r_sb;         // divisor/multiplier was negative (signed ops only)
  logic                 r_dvsr_zero;
  logic [WIDTH-1:0]     r_rs_raw;     // original rs, returned in HI on divide by zero
  logic [WIDTH-1:0]     r_a;          // divide: dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]     r_b;          // multiply: multiplier shifting right; divide: divisor
  logic [WIDTH-1:0]     r_rem;        // divide partial remainder
  logic [2*WIDTH-1:0]   r_acc;        // multiply product accumulator
  logic [2*WIDTH-1:0]   r_mcand;      // multiplicand, shifted left each iteration
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed_op;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_shifted;
  logic [WIDTH:0]       w_diff;
  logic                 w_no_borrow;
  logic [2*WIDTH-1:0]   w_prod_signed;

  // Magnitudes: the WIDTH-bit two's complement of the most negative value
  // reads correctly as its unsigned magnitude, so no extra bit is needed.
  assign w_signed_op   = ~bus.op[0];
  assign w_a_mag       = (w_signed_op && bus.rs[WIDTH-1]) ? (~bus.rs + 1'b1) : bus.rs;
  assign w_b_mag       = (w_signed_op && bus.rt[WIDTH-1]) ? (~bus.rt + 1'b1) : bus.rt;

  // Restoring divide step: bring the next dividend bit into the remainder
  assign w_shifted     = {r_rem, r_a[WIDTH-1]};
  assign w_diff        = w_shifted - {1'b0, r_b};
  assign w_no_borrow   = ~w_diff[WIDTH];

  assign w_prod_signed = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept in IDLE, iterate in CALC, one sign-fix cycle in FIN
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        if (r_count == LAST_ITER) begin
          w_next = S_FIN;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!r_is_div && (r_b[WIDTH-1:1] == '0)) begin
          w_next = S_FIN;
        end
`endif
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, one multiply/divide iteration per cycle, result write-back
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_count     <= '0;
      r_is_div    <= 1'b0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_dvsr_zero <= 1'b0;
      r_rs_raw    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.wr_hi) begin
            r_hi <= bus.wr_data;
          end
          if (bus.wr_lo) begin
            r_lo <= bus.wr_data;
          end
          if (bus.start) begin
            r_is_div    <= bus.op[1];
            r_sa        <= w_signed_op & bus.rs[WIDTH-1];
            r_sb        <= w_signed_op & bus.rt[WIDTH-1];
            r_dvsr_zero <= (bus.rt == '0);
            r_rs_raw    <= bus.rs;
            r_a         <= w_a_mag;
            r_b         <= w_b_mag;
            r_rem       <= '0;
            r_acc       <= '0;
            r_mcand     <= {{WIDTH{1'b0}}, w_a_mag};
            r_count     <= '0;
            r_busy      <= 1'b1;
          end
        end
        S_CALC: begin
          r_count <= r_count + 1'b1;
          if (r_is_div) begin
            r_a   <= {r_a[WIDTH-2:0], w_no_borrow};
            r_rem <= w_no_borrow ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
          end else begin
            if (r_b[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
          end
        end
        S_FIN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_is_div) begin
            if (r_dvsr_zero) begin
              r_hi  <= r_rs_raw;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_lo <= (r_sa ^ r_sb) ? (~r_a + 1'b1) : r_a;
              r_hi <= r_sa ? (~r_rem + 1'b1) : r_rem;
            end
          end else begin
            r_hi <= w_prod_signed[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_signed[WIDTH-1:0];
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
